// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target (mode 0, MSB first, 8-bit frames).
package spi_target_pkg;

  typedef enum logic {
    SpiIdle   = 1'b0,
    SpiActive = 1'b1
  } spi_state_e;

  localparam int unsigned SpiByteW      = 8;
  localparam int unsigned SpiSyncStages = 2;
  localparam int unsigned SpiCntW       = $clog2(SpiByteW);

  // Byte to place in the TX shifter: the offered byte if there is one, else the idle filler.
  function automatic logic [SpiByteW-1:0] tx_select(input logic                valid,
                                                    input logic [SpiByteW-1:0] data,
                                                    input logic [SpiByteW-1:0] idle);
    return valid ? data : idle;
  endfunction

endpackage

// File: rtl/spi_target_if.sv
// CPU-side byte streams of the SPI target: RX bytes out of the FIFO, TX bytes into the shifter.
interface spi_target_if;
  import spi_target_pkg::*;

  // valid/ready: a byte moves on a clock edge where both are high; valid may not depend on
  // ready, and data is held stable while valid is high and ready is low.
  logic [SpiByteW-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [SpiByteW-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/spi_target_rx_fifo.sv
// Small synchronous FIFO holding received bytes; pointers carry an extra wrap bit.
module spi_target_rx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) &&
                   (wptr_q[AddrW] != rptr_q[AddrW]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/spi_target.sv
// SPI target: oversamples SCK/CS_n/COPI in the system clock domain, fills an RX FIFO, shifts TX bytes on CIPO.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned         RxDepth    = 4,
  parameter logic [SpiByteW-1:0] TxIdleByte = 8'hFF
) (
  input  logic         clk_sys_i,
  input  logic         rst_sys_ni,
  input  logic         spi_sck_i,
  input  logic         spi_cs_ni,
  input  logic         spi_copi_i,
  output logic         spi_cipo_o,
  output logic         spi_cipo_en_o,
  spi_target_if.slave  host,
  output logic         rx_overflow_o,
  output logic         active_o,
  output spi_state_e   state_o
);

  logic [SpiSyncStages-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
  logic                     sck_dly_q, cs_dly_q;
  logic                     sck_s, cs_s, copi_s;
  logic                     sck_rise, sck_fall, cs_fall;

  spi_state_e          state_q, state_d;
  logic [SpiCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SpiByteW-1:0] rx_shift_q, rx_shift_d;
  logic [SpiByteW-1:0] tx_shift_q, tx_shift_d;
  logic                push_q, push_d;
  logic                rx_overflow_q, rx_overflow_d;
  logic                tx_load;

  logic [SpiByteW-1:0] fifo_data;
  logic                fifo_full, fifo_empty, fifo_pop;

  // CS_n idles high through reset so releasing reset never looks like a select.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SpiSyncStages-2:0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[SpiSyncStages-2:0], spi_cs_ni};
      copi_sync_q <= {copi_sync_q[SpiSyncStages-2:0], spi_copi_i};
      sck_dly_q   <= sck_sync_q[SpiSyncStages-1];
      cs_dly_q    <= cs_sync_q[SpiSyncStages-1];
    end
  end

  assign sck_s    = sck_sync_q[SpiSyncStages-1];
  assign cs_s     = cs_sync_q[SpiSyncStages-1];
  assign copi_s   = copi_sync_q[SpiSyncStages-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    push_d     = 1'b0;
    tx_load    = 1'b0;

    unique case (state_q)
      SpiIdle: begin
        if (cs_fall) begin
          state_d   = SpiActive;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      SpiActive: begin
        if (cs_s) begin
          // Deselect drops any partial byte and the loaded TX byte.
          state_d   = SpiIdle;
          bit_cnt_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[SpiByteW-2:0], copi_s};
          bit_cnt_d  = bit_cnt_q + SpiCntW'(1);
          push_d     = (bit_cnt_q == SpiCntW'(SpiByteW - 1));
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
          else                 tx_load    = 1'b1;
        end
      end
      default: state_d = SpiIdle;
    endcase

    if (tx_load) tx_shift_d = tx_select(host.tx_valid, host.tx_data, TxIdleByte);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q       <= SpiIdle;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      push_q        <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      push_q        <= push_d;
      rx_overflow_q <= rx_overflow_d;
    end
  end

  // The completed byte is written one cycle after the 8th rising edge updates rx_shift.
  assign fifo_pop      = host.rx_ready & ~fifo_empty;
  assign rx_overflow_d = push_q & fifo_full & ~fifo_pop;

  spi_target_rx_fifo #(
    .Depth (RxDepth),
    .Width (SpiByteW)
  ) u_rx_fifo (
    .clk_i   (clk_sys_i),
    .rst_ni  (rst_sys_ni),
    .push_i  (push_q),
    .data_i  (rx_shift_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign host.rx_data  = fifo_data;
  assign host.rx_valid = ~fifo_empty;
  assign host.tx_ready = tx_load & host.tx_valid;

  assign active_o      = (state_q == SpiActive);
  assign spi_cipo_en_o = active_o;
  assign spi_cipo_o    = active_o & tx_shift_q[SpiByteW-1];
  assign rx_overflow_o = rx_overflow_q;
  assign state_o       = state_q;

endmodule
